// File: rtl/prbs7_check_ctrl.sv
// Run controller for the 32-bit PRBS7 checker: acquires lock, counts errored
// bits/words over an optional window and tracks loss-of-lock events.
module prbs7_check_ctrl #(
    parameter int DATA_W     = 32,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 32,
    parameter int WORD_W     = 48
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic [WORD_W-1:0] window_len,
    input  logic [DATA_W-1:0] bit_error,
    output logic [1:0]        state,
    output logic              locked,
    output logic              done,
    output logic [WORD_W-1:0] word_count,
    output logic [ERR_W-1:0]  err_count,
    output logic [ERR_W-1:0]  err_word_count,
    output logic [15:0]       unlock_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int POP_W   = $clog2(DATA_W + 1);
    localparam int RUN_W   = $clog2(LOCK_CNT + 1);
    localparam int BAD_W   = $clog2(UNLOCK_CNT + 1);
    localparam int ERR_W1  = ERR_W + 1;
    localparam int WORD_W1 = WORD_W + 1;

    state_t            st_q, st_nx;
    logic [DATA_W-1:0] be_q;
    logic              sync_q, lock_q;
    logic [RUN_W-1:0]  run_cnt, run_nx;
    logic [BAD_W-1:0]  bad_cnt, bad_nx;
    logic [WORD_W-1:0] win_q, win_nx, word_nx, word_inc;
    logic [ERR_W-1:0]  err_nx, errw_nx, err_inc, errw_inc;
    logic [15:0]       unl_nx, unl_inc;
    logic [POP_W-1:0]  pop;
    logic              any_err, accum, sync_eval, lock_eval;
    logic [WORD_W:0]   word_sum;
    logic [ERR_W:0]    err_sum, errw_sum;
    logic [16:0]       unl_sum;

    assign state   = st_q;
    assign any_err = |be_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_W; i++)
            pop = pop + POP_W'(be_q[i]);
    end

    // Every counter sticks at all-ones instead of wrapping.
    assign word_sum = {1'b0, word_count} + WORD_W1'(1);
    assign err_sum  = {1'b0, err_count} + ERR_W1'(pop);
    assign errw_sum = {1'b0, err_word_count} + ERR_W1'(1);
    assign unl_sum  = {1'b0, unlock_count} + 17'd1;
    assign word_inc = word_sum[WORD_W] ? '1 : word_sum[WORD_W-1:0];
    assign err_inc  = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    assign errw_inc = errw_sum[ERR_W] ? '1 : errw_sum[ERR_W-1:0];
    assign unl_inc  = unl_sum[16] ? '1 : unl_sum[15:0];

    // The qualifiers travel with be_q, so a word is judged by the state it arrived in;
    // the word still in flight when an unlock happens is counted in SYNC.
    assign accum     = lock_q && (st_q == ST_LOCKED || st_q == ST_SYNC);
    assign lock_eval = lock_q && (st_q == ST_LOCKED);
    assign sync_eval = sync_q && (st_q == ST_SYNC);

    always_comb begin
        st_nx   = st_q;
        run_nx  = run_cnt;
        bad_nx  = bad_cnt;
        win_nx  = win_q;
        word_nx = word_count;
        err_nx  = err_count;
        errw_nx = err_word_count;
        unl_nx  = unlock_count;

        if (accum) begin
            word_nx = word_inc;
            err_nx  = err_inc;
            if (any_err)
                errw_nx = errw_inc;
        end

        if (sync_eval) begin
            if (any_err) begin
                run_nx = '0;
            end else if (run_cnt == RUN_W'(LOCK_CNT - 1)) begin
                run_nx = '0;
                bad_nx = '0;
                st_nx  = ST_LOCKED;
            end else begin
                run_nx = run_cnt + RUN_W'(1);
            end
        end

        if (lock_eval) begin
            if (!any_err) begin
                bad_nx = '0;
            end else if (bad_cnt == BAD_W'(UNLOCK_CNT - 1)) begin
                bad_nx = '0;
                run_nx = '0;
                unl_nx = unl_inc;
                st_nx  = ST_SYNC;
            end else begin
                bad_nx = bad_cnt + BAD_W'(1);
            end
            // Window end overrides a simultaneous unlock.
            if (win_q != '0 && word_inc >= win_q)
                st_nx = ST_DONE;
        end

        if (stop) begin
            st_nx   = ST_IDLE;
            run_nx  = '0;
            bad_nx  = '0;
            word_nx = word_count;
            err_nx  = err_count;
            errw_nx = err_word_count;
            unl_nx  = unlock_count;
        end else if (start) begin
            st_nx   = ST_SYNC;
            run_nx  = '0;
            bad_nx  = '0;
            win_nx  = window_len;
            word_nx = '0;
            err_nx  = '0;
            errw_nx = '0;
            unl_nx  = '0;
        end else if (clear) begin
            word_nx = '0;
            err_nx  = '0;
            errw_nx = '0;
            unl_nx  = '0;
        end
    end

    // A start or stop kills the in-flight qualifiers so a new run begins clean.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q           <= ST_IDLE;
            locked         <= 1'b0;
            done           <= 1'b0;
            be_q           <= '0;
            sync_q         <= 1'b0;
            lock_q         <= 1'b0;
            run_cnt        <= '0;
            bad_cnt        <= '0;
            win_q          <= '0;
            word_count     <= '0;
            err_count      <= '0;
            err_word_count <= '0;
            unlock_count   <= '0;
        end else begin
            st_q           <= st_nx;
            locked         <= (st_nx == ST_LOCKED);
            done           <= (st_nx == ST_DONE);
            be_q           <= bit_error;
            sync_q         <= (st_q == ST_SYNC) && !start && !stop;
            lock_q         <= (st_q == ST_LOCKED) && !start && !stop;
            run_cnt        <= run_nx;
            bad_cnt        <= bad_nx;
            win_q          <= win_nx;
            word_count     <= word_nx;
            err_count      <= err_nx;
            err_word_count <= errw_nx;
            unlock_count   <= unl_nx;
        end
    end

endmodule

// File: tb/tb_prbs7_check_ctrl.sv
// Scenario bench for prbs7_check_ctrl; a second instance with 8-bit error
// counters exercises saturation.
module tb_prbs7_check_ctrl;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b1;
    logic        start      = 1'b0;
    logic        stop       = 1'b0;
    logic        clear      = 1'b0;
    logic [47:0] window_len = '0;
    logic [31:0] bit_error  = '0;

    logic [1:0]  state, state_s;
    logic        locked, done, locked_s, done_s;
    logic [47:0] word_count, word_count_s;
    logic [31:0] err_count, err_word_count;
    logic [7:0]  err_count_s, err_word_count_s;
    logic [15:0] unlock_count, unlock_count_s;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int          due;
        logic [47:0] word;
        logic [31:0] err;
        logic [31:0] errw;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [47:0] exp_word;
    logic [31:0] exp_err, exp_errw;

    prbs7_check_ctrl dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .window_len(window_len), .bit_error(bit_error), .state(state),
        .locked(locked), .done(done), .word_count(word_count), .err_count(err_count),
        .err_word_count(err_word_count), .unlock_count(unlock_count)
    );

    prbs7_check_ctrl #(.ERR_W(8)) dut_sat (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .window_len(window_len), .bit_error(bit_error), .state(state_s),
        .locked(locked_s), .done(done_s), .word_count(word_count_s), .err_count(err_count_s),
        .err_word_count(err_word_count_s), .unlock_count(unlock_count_s)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Counted words surface two edges after they are sampled.
    always @(posedge clock) begin
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            vectors++;
            if (word_count !== mon_e.word) begin
                miscompares++;
                $display("[TB] FAIL sb_word cyc=%0d got %0d want %0d", cyc, word_count, mon_e.word);
            end
            vectors++;
            if (err_count !== mon_e.err) begin
                miscompares++;
                $display("[TB] FAIL sb_err cyc=%0d got %0d want %0d", cyc, err_count, mon_e.err);
            end
            vectors++;
            if (err_word_count !== mon_e.errw) begin
                miscompares++;
                $display("[TB] FAIL sb_errw cyc=%0d got %0d want %0d", cyc, err_word_count, mon_e.errw);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_model();
        exp_word = '0;
        exp_err  = '0;
        exp_errw = '0;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_t e;
        bit_error = w;
        exp_word  = exp_word + 48'd1;
        exp_err   = exp_err + 32'($countones(w));
        exp_errw  = exp_errw + ((w != '0) ? 32'd1 : 32'd0);
        e.due  = cyc + 2;
        e.word = exp_word;
        e.err  = exp_err;
        e.errw = exp_errw;
        sb.push_back(e);
        tick();
    endtask

    task automatic begin_run(input logic [47:0] win);
        window_len = win;
        bit_error  = '0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        reset_model();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({state, locked, done} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state got %b want 0000", {state, locked, done});
        end
        vectors++;
        if ({word_count, err_count, err_word_count, unlock_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_counters got %0d/%0d/%0d/%0d want 0", word_count, err_count, err_word_count, unlock_count);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_lock();
        begin_run(48'd0);
        vectors++;
        if (state !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL lock_enter_sync state=%0d want 1", state);
        end
        repeat (64) tick();
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lock_early locked=%0b want 0", locked);
        end
        tick();
        vectors++;
        if (locked !== 1'b1 || state !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL lock_rise locked=%0b state=%0d want 1/2", locked, state);
        end
        for (int i = 0; i < 30; i++) push_word(32'h0);
        vectors++;
        if (word_count !== 48'd29 || err_count !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL lock_count words=%0d errs=%0d want 29/0", word_count, err_count);
        end
    endtask

    task automatic test_single_error();
        push_word(32'h0000_0101);
        push_word(32'h0);
        vectors++;
        if (err_count !== 32'd2 || err_word_count !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL single_err errs=%0d words=%0d want 2/1", err_count, err_word_count);
        end
        repeat (5) push_word(32'h0);
        vectors++;
        if (state !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL single_state state=%0d want 2", state);
        end
    endtask

    task automatic test_unlock_relock();
        repeat (4) push_word(32'h8000_0000);
        push_word(32'h0);
        vectors++;
        if (state !== 2'd1 || unlock_count !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL unlock state=%0d unlocks=%0d want 1/1", state, unlock_count);
        end
        vectors++;
        if (err_count !== 32'd6) begin
            miscompares++;
            $display("[TB] FAIL unlock_errs got %0d want 6", err_count);
        end
        repeat (64) tick();
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL relock_early locked=%0b want 0", locked);
        end
        tick();
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL relock locked=%0b want 1", locked);
        end
        push_word(32'h0);
        push_word(32'h0);
        vectors++;
        if (word_count !== exp_word - 48'd1) begin
            miscompares++;
            $display("[TB] FAIL relock_words got %0d want %0d", word_count, exp_word - 48'd1);
        end
    endtask

    task automatic test_clear_locked();
        bit_error = 32'h0000_000F;
        tick();
        clear = 1'b1;
        reset_model();
        push_word(32'h0);
        clear = 1'b0;
        vectors++;
        if ({word_count, err_count, err_word_count, unlock_count} !== '0 || state !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL clear_locked words=%0d errs=%0d state=%0d want 0/0/2", word_count, err_count, state);
        end
        push_word(32'h0);
        vectors++;
        if (word_count !== 48'd1) begin
            miscompares++;
            $display("[TB] FAIL clear_resume words=%0d want 1", word_count);
        end
    endtask

    task automatic test_stop_start();
        push_word(32'h0000_00F0);
        push_word(32'h0);
        push_word(32'h0);
        bit_error = '0;
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        vectors++;
        if (state !== 2'd0 || word_count !== exp_word || err_count !== 32'd4 || err_word_count !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL stop_hold state=%0d words=%0d errs=%0d want 0/%0d/4", state, word_count, err_count, exp_word);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) tick();
        vectors++;
        if (state !== 2'd0 || word_count !== exp_word) begin
            miscompares++;
            $display("[TB] FAIL idle_stop state=%0d words=%0d want 0/%0d", state, word_count, exp_word);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        reset_model();
        vectors++;
        if ({word_count, err_count, err_word_count, unlock_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL clear_idle words=%0d errs=%0d want 0", word_count, err_count);
        end
    endtask

    task automatic test_window();
        begin_run(48'd1000);
        repeat (65) tick();
        for (int i = 0; i < 1000; i++) push_word(32'h0);
        vectors++;
        if (done !== 1'b0 || word_count !== 48'd999) begin
            miscompares++;
            $display("[TB] FAIL window_pre done=%0b words=%0d want 0/999", done, word_count);
        end
        bit_error = '0;
        tick();
        vectors++;
        if (done !== 1'b1 || state !== 2'd3 || word_count !== 48'd1000) begin
            miscompares++;
            $display("[TB] FAIL window_end done=%0b state=%0d words=%0d want 1/3/1000", done, state, word_count);
        end
        repeat (50) tick();
        vectors++;
        if (done !== 1'b1 || word_count !== 48'd1000 || err_count !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL window_frozen done=%0b words=%0d want 1/1000", done, word_count);
        end
    endtask

    task automatic test_unlock_window();
        begin_run(48'd4);
        vectors++;
        if (state !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL restart_from_done state=%0d want 1", state);
        end
        repeat (65) tick();
        repeat (4) push_word(32'h0000_0001);
        vectors++;
        if (done !== 1'b0 || word_count !== 48'd3) begin
            miscompares++;
            $display("[TB] FAIL uw_pre done=%0b words=%0d want 0/3", done, word_count);
        end
        bit_error = '0;
        tick();
        vectors++;
        if (done !== 1'b1 || unlock_count !== 16'd1 || word_count !== 48'd4 || err_count !== 32'd4) begin
            miscompares++;
            $display("[TB] FAIL uw_end done=%0b unlocks=%0d words=%0d errs=%0d want 1/1/4/4", done, unlock_count, word_count, err_count);
        end
        repeat (3) tick();
        vectors++;
        if (word_count !== 48'd4) begin
            miscompares++;
            $display("[TB] FAIL uw_frozen words=%0d want 4", word_count);
        end
    endtask

    task automatic test_saturation();
        begin_run(48'd0);
        repeat (65) tick();
        for (int i = 0; i < 7; i++) begin
            push_word(32'hFFFF_FFFF);
            push_word(32'h0);
        end
        vectors++;
        if (err_count_s !== 8'd224 || err_count !== 32'd224) begin
            miscompares++;
            $display("[TB] FAIL sat_pre small=%0d big=%0d want 224/224", err_count_s, err_count);
        end
        for (int i = 0; i < 2; i++) begin
            push_word(32'hFFFF_FFFF);
            push_word(32'h0);
        end
        vectors++;
        if (err_count_s !== 8'hFF || err_word_count_s !== 8'd9) begin
            miscompares++;
            $display("[TB] FAIL sat_small errs=%0d words=%0d want 255/9", err_count_s, err_word_count_s);
        end
        vectors++;
        if (err_count !== 32'd288) begin
            miscompares++;
            $display("[TB] FAIL sat_big errs=%0d want 288", err_count);
        end
        bit_error = '0;
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sb_drain pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_reset_midrun();
        reset_n = 1'b0;
        #2;
        vectors++;
        if ({state, locked, done, word_count, err_count, err_word_count, unlock_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset state=%0d words=%0d errs=%0d want 0", state, word_count, err_count);
        end
        vectors++;
        if ({state_s, locked_s, done_s, word_count_s, err_count_s, err_word_count_s, unlock_count_s} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset_small state=%0d errs=%0d want 0", state_s, err_count_s);
        end
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_model();
        test_reset();
        test_lock();
        test_single_error();
        test_unlock_relock();
        test_clear_locked();
        test_stop_start();
        test_window();
        test_unlock_window();
        test_saturation();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
